// File: rtl/pcie_write_arbiter.sv
// Round-robin arbiter that hands one requester packet at a time to a PCIe write module,
// tagging each packet with a per-requester sequence bit and watching for a stalled start.
module pcie_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 128,
  parameter int TMO  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*DW-1:0]       i_req_data,
  output logic [NREQ-1:0]          o_req_ack,
  output logic                     o_wm_enable,
  output logic [DW-1:0]            o_wm_data,
  output logic [$clog2(NREQ)-1:0]  o_wm_core_id,
  input  logic                     i_wm_ready,
  output logic                     o_busy,
  output logic [15:0]              o_issued_cnt,
  output logic                     o_err_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_ISSUE      = 2'd1;
  localparam logic [1:0] S_WAIT_START = 2'd2;
  localparam logic [1:0] S_WAIT_DONE  = 2'd3;

  logic [1:0]      r_state;
  logic [IW-1:0]   r_lastGrant;
  logic [IW-1:0]   r_coreId;
  logic [DW-1:0]   r_wmData;
  logic [NREQ-1:0] r_seq;
  logic [CW-1:0]   r_tmoCnt;
  logic [15:0]     r_issuedCnt;
  logic            r_errTimeout;

  logic [IW-1:0]   w_winner;
  logic [IW-1:0]   w_idx;
  logic            w_found;

  // Scan starts just after the last grant and wraps, so the first hit is the round-robin winner.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_lastGrant) + k) % NREQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_lastGrant  <= IW'(NREQ - 1);
      r_coreId     <= '0;
      r_wmData     <= '0;
      r_seq        <= '0;
      r_tmoCnt     <= '0;
      r_issuedCnt  <= '0;
      r_errTimeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The top bit already carries the value the sequence bit takes after this grant.
          if (i_wm_ready && w_found) begin
            r_state  <= S_ISSUE;
            r_coreId <= w_winner;
            r_wmData <= {~r_seq[w_winner], i_req_data[int'(w_winner)*DW +: DW-1]};
          end
        end
        S_ISSUE: begin
          r_seq[r_coreId] <= ~r_seq[r_coreId];
          r_tmoCnt        <= '0;
          r_state         <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (!i_wm_ready) begin
            r_state <= S_WAIT_DONE;
          end else if (r_tmoCnt == CW'(TMO - 1)) begin
            r_errTimeout <= 1'b1;
            r_lastGrant  <= r_coreId;
            r_state      <= S_IDLE;
          end else begin
            r_tmoCnt <= r_tmoCnt + CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (i_wm_ready) begin
            r_issuedCnt <= r_issuedCnt + 16'd1;
            r_lastGrant <= r_coreId;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ack     = (r_state == S_ISSUE) ? (NREQ'(1) << r_coreId) : '0;
  assign o_wm_enable   = (r_state == S_ISSUE);
  assign o_wm_data     = r_wmData;
  assign o_wm_core_id  = r_coreId;
  assign o_busy        = (r_state != S_IDLE);
  assign o_issued_cnt  = r_issuedCnt;
  assign o_err_timeout = r_errTimeout;

endmodule
